// File: rtl/uart_config_requester.sv
// Initiator of the UART runtime-configuration handshake: SYN burst, DW/PM/SB/END packets, ACK per packet.
// Latency: first SYN presented the cycle after req_i; done_o/fail_o are registered one-cycle pulses.
// Backpressure: tx bytes held stable while tx_ready_i is low; rx bytes outside WAIT_ACK are dropped.
module uart_config_requester #(
  parameter int         SYN_NUMBER     = 3,
  parameter logic [7:0] SYN_CHAR       = 8'h16,
  parameter logic [7:0] ACK_CHAR       = 8'h06,
  parameter int         COUNT_1MS      = 50000,
  parameter int         ACK_TIMEOUT_MS = 10
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [5:0] config_o
);

  localparam int TMO_LIMIT = ACK_TIMEOUT_MS * COUNT_1MS;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam int SYN_W     = (SYN_NUMBER > 1) ? $clog2(SYN_NUMBER) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_LIMIT);
  // Expiry is decided on the edge where the counter would reach TMO_LIMIT,
  // so fail_o rises exactly TMO_LIMIT edges after the packet transfer edge.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
  localparam logic [SYN_W-1:0] SYN_LAST = SYN_W'(SYN_NUMBER - 1);

  typedef enum logic [1:0] {IDLE, SEND_SYN, SEND_PKT, WAIT_ACK} state_t;

  state_t           state, state_next;
  logic [SYN_W-1:0] syn_cnt, syn_cnt_next;
  logic [1:0]       pkt_idx, pkt_idx_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
  logic [1:0]       dw_q, dw_next, pm_q, pm_next, sb_q, sb_next;
  logic [5:0]       cfg_next;
  logic             done_next, fail_next;
  logic [7:0]       pkt_byte;

  assign busy_o = (state != IDLE);

  // Packet byte for the current index: {4'b0000, code, id}; END carries code 00.
  always_comb begin
    pkt_byte = 8'h00;
    case (pkt_idx)
      2'd0:    pkt_byte = {4'b0000, dw_q, 2'b01};
      2'd1:    pkt_byte = {4'b0000, pm_q, 2'b10};
      2'd2:    pkt_byte = {4'b0000, sb_q, 2'b11};
      default: pkt_byte = 8'h00;
    endcase
  end

  // State register plus counters, latched codes, committed config and result pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      syn_cnt  <= '0;
      pkt_idx  <= 2'd0;
      tmo_cnt  <= '0;
      dw_q     <= 2'b00;
      pm_q     <= 2'b00;
      sb_q     <= 2'b00;
      config_o <= 6'b00_00_11;
      done_o   <= 1'b0;
      fail_o   <= 1'b0;
    end else begin
      state    <= state_next;
      syn_cnt  <= syn_cnt_next;
      pkt_idx  <= pkt_idx_next;
      tmo_cnt  <= tmo_cnt_next;
      dw_q     <= dw_next;
      pm_q     <= pm_next;
      sb_q     <= sb_next;
      config_o <= cfg_next;
      done_o   <= done_next;
      fail_o   <= fail_next;
    end
  end

  // Next-state logic and TX outputs; the ACK check precedes the timeout so a same-cycle ACK wins.
  always_comb begin
    state_next   = state;
    syn_cnt_next = syn_cnt;
    pkt_idx_next = pkt_idx;
    tmo_cnt_next = tmo_cnt;
    dw_next      = dw_q;
    pm_next      = pm_q;
    sb_next      = sb_q;
    cfg_next     = config_o;
    done_next    = 1'b0;
    fail_next    = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (stop_bits_i[1]) begin
            fail_next = 1'b1;
          end else begin
            dw_next      = data_width_i;
            pm_next      = parity_mode_i;
            sb_next      = stop_bits_i;
            syn_cnt_next = '0;
            pkt_idx_next = 2'd0;
            state_next   = SEND_SYN;
          end
        end
      end
      SEND_SYN: begin
        tx_valid_o = 1'b1;
        tx_data_o  = SYN_CHAR;
        if (tx_ready_i) begin
          if (syn_cnt == SYN_LAST) begin
            syn_cnt_next = '0;
            pkt_idx_next = 2'd0;
            state_next   = SEND_PKT;
          end else begin
            syn_cnt_next = syn_cnt + 1'b1;
          end
        end
      end
      SEND_PKT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = pkt_byte;
        if (tx_ready_i) begin
          tmo_cnt_next = '0;
          state_next   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tmo_cnt != TMO_MAX) tmo_cnt_next = tmo_cnt + 1'b1;
        if (rx_valid_i && (rx_data_i == ACK_CHAR)) begin
          if (pkt_idx == 2'd3) begin
            cfg_next   = {sb_q, pm_q, dw_q};
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            pkt_idx_next = pkt_idx + 2'd1;
            state_next   = SEND_PKT;
          end
        end else if (rx_valid_i) begin
          fail_next  = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          fail_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_config_requester.sv
// Bench for uart_config_requester: table of request scenarios plus hand-written reserved-code and reset cases.
// Latency: one stimulus update per clock, driven 1 time unit after the rising edge.
// Backpressure: tx_ready toggled every 3 cycles in backpressure scenarios; TX bytes checked against a queue.
module tb_uart_config_requester;

  localparam int COUNT_1MS      = 10;
  localparam int ACK_TIMEOUT_MS = 2;
  localparam int TMO            = ACK_TIMEOUT_MS * COUNT_1MS;
  localparam int ACK_DELAY      = 5;

  logic       clk = 1'b0;
  logic       rst_n, req, tx_ready, rx_valid, tx_valid, busy, done, fail;
  logic [1:0] dw, pm, sb;
  logic [7:0] tx_data, rx_data;
  logic [5:0] cfg;

  always #5 clk = ~clk;

  uart_config_requester #(
    .SYN_NUMBER(3), .SYN_CHAR(8'h16), .ACK_CHAR(8'h06),
    .COUNT_1MS(COUNT_1MS), .ACK_TIMEOUT_MS(ACK_TIMEOUT_MS)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
    .data_width_i(dw), .parity_mode_i(pm), .stop_bits_i(sb),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .busy_o(busy), .done_o(done), .fail_o(fail), .config_o(cfg)
  );

  typedef struct {
    logic [1:0] dw, pm, sb;
    bit         bp;        // toggle tx_ready
    bit         stray;     // inject a stray ACK during the SYN stream
    int         bad_pkt;   // 1..4: packet that gets a bad answer, 0: none
    bit         bad_nak;   // 1: answer NAK, 0: stay silent
    bit         exp_done;
    logic [5:0] exp_cfg;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int edges = 0, ack_cnt = 0, pkt_no = 0, bad_pkt = 0;
  int done_cnt = 0, fail_cnt = 0, done_edge = -1, fail_edge = -1;
  int pkt_edge[8];
  bit bp = 0, stray_pend = 0, bad_nak = 0, prev_stall = 0, valid_seen = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then drive inputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, prev_data);
    end
    prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
    prev_data  = tx_data;
    if (tx_valid === 1'b1) valid_seen = 1;
    if (done === 1'b1 || fail === 1'b1) chk("done_fail_exclusive", done & fail, 0);
    if (done === 1'b1) begin done_cnt++; done_edge = edges; end
    if (fail === 1'b1) begin fail_cnt++; fail_edge = edges; end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_unexpected: got %0h, expected no byte", tx_data);
      end else begin
        chk("tx_byte", tx_data, exp_q.pop_front());
      end
      if (tx_data != 8'h16) begin
        pkt_no++;
        if (pkt_no < 8) pkt_edge[pkt_no] = edges + 1;
        if (!(pkt_no == bad_pkt && !bad_nak)) ack_cnt = ACK_DELAY;
      end
    end
    @(posedge clk);
    edges++;
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        rx_valid = 1'b1;
        rx_data  = (pkt_no == bad_pkt) ? 8'h15 : 8'h06;
      end
    end else if (stray_pend && tx_valid === 1'b1 && tx_data == 8'h16) begin
      rx_valid   = 1'b1;
      rx_data    = 8'h06;
      stray_pend = 0;
    end
    tx_ready = bp ? (((edges / 3) % 2) == 1) : 1'b1;
  endtask

  task automatic push_request(input logic [1:0] d, input logic [1:0] p, input logic [1:0] s, input int stop_after);
    logic [7:0] pk[5];
    pk[1] = {4'b0000, d, 2'b01};
    pk[2] = {4'b0000, p, 2'b10};
    pk[3] = {4'b0000, s, 2'b11};
    pk[4] = 8'h00;
    repeat (3) exp_q.push_back(8'h16);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(pk[i]);
      if (i == stop_after) break;
    end
  endtask

  task automatic pulse_req(input logic [1:0] d, input logic [1:0] p, input logic [1:0] s);
    req = 1'b1; dw = d; pm = p; sb = s;
    tick();
    req = 1'b0;
  endtask

  task automatic run_req(input vec_t v, input string tag);
    bp = v.bp; stray_pend = v.stray; bad_pkt = v.bad_pkt; bad_nak = v.bad_nak;
    pkt_no = 0; done_cnt = 0; fail_cnt = 0; done_edge = -1; fail_edge = -1; ack_cnt = 0;
    push_request(v.dw, v.pm, v.sb, v.bad_pkt);
    pulse_req(v.dw, v.pm, v.sb);
    for (int n = 0; n < 800 && done_cnt == 0 && fail_cnt == 0; n++) tick();
    if (done_cnt == 0 && fail_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_no_result: got no done/fail pulse, expected one within 800 cycles", tag);
    end
    repeat (4) tick();
    chk({tag, "_done_count"}, done_cnt, v.exp_done);
    chk({tag, "_fail_count"}, fail_cnt, !v.exp_done);
    chk({tag, "_config"}, cfg, v.exp_cfg);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_tx_remaining"}, exp_q.size(), 0);
    if (v.bad_pkt != 0 && !v.bad_nak) chk({tag, "_timeout_cycles"}, fail_edge - pkt_edge[v.bad_pkt], TMO);
    if (v.stray) chk({tag, "_stray_injected"}, stray_pend, 0);
    exp_q.delete();
    bp = 0; stray_pend = 0; bad_pkt = 0;
  endtask

  initial begin
    //          dw     pm     sb     bp    stray bad nak   done  cfg
    vecs[0] = '{2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 2, 1'b1, 1'b0, 6'b00_00_11}; // NAK to parity packet
    vecs[1] = '{2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 1, 1'b0, 1'b0, 6'b00_00_11}; // silence after DW packet
    vecs[2] = '{2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 6'b01_01_10}; // nominal
    vecs[3] = '{2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 6'b00_10_11}; // other codes
    vecs[4] = '{2'b10, 2'b01, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1'b1, 6'b01_01_10}; // tx backpressure
    vecs[5] = '{2'b01, 2'b11, 2'b01, 1'b0, 1'b1, 0, 1'b0, 1'b1, 6'b01_11_01}; // stray RX during SYN

    rst_n = 1'b0; req = 1'b0; dw = 2'b00; pm = 2'b00; sb = 2'b00;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_config", cfg, 6'b00_00_11);
    rst_n = 1'b1;
    tick();

    // Reserved stop-bits code: immediate fail, nothing transmitted.
    fail_cnt = 0; valid_seen = 0;
    pulse_req(2'b10, 2'b01, 2'b10);
    chk("rsv_fail_pulse", fail, 1);
    chk("rsv_busy", busy, 0);
    chk("rsv_tx_valid", tx_valid, 0);
    repeat (5) tick();
    chk("rsv_fail_count", fail_cnt, 1);
    chk("rsv_no_tx", valid_seen, 0);
    chk("rsv_config", cfg, 6'b00_00_11);

    for (int i = 0; i < 6; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for the ACK of the stop-bits packet.
    bad_pkt = 3; bad_nak = 0; pkt_no = 0; ack_cnt = 0;
    push_request(2'b10, 2'b01, 2'b01, 3);
    pulse_req(2'b10, 2'b01, 2'b01);
    for (int n = 0; n < 300 && pkt_no < 3; n++) tick();
    repeat (3) tick();
    chk("mid_reached_sb", pkt_no, 3);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_config", cfg, 6'b00_00_11);
    chk("mid_rst_tx_remaining", exp_q.size(), 0);
    bad_pkt = 0;
    tick();
    run_req(vecs[2], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_config_requester.md
Name: uart_config_requester

Overview:
- Initiator side of the UART runtime-configuration protocol; the counterpart of the receiver-side configuration decoder.
- On request it:
  - sends SYN_NUMBER SYN characters through the transmitter;
  - sends one configuration packet each for data width, parity mode and stop bits, then the end-configuration packet;
  - waits for an ACK character after each packet.
- Sits between host control logic and the TX/RX byte paths of the UART; commits the new configuration only after the final ACK.

Parameters:
- SYN_NUMBER, 3, number of consecutive SYN characters opening a request.
- SYN_CHAR, 8'h16, SYN character value.
- ACK_CHAR, 8'h06, acknowledge character expected from the remote end.
- COUNT_1MS, 50000, clock cycles per millisecond (SYSTEM_CLOCK_FREQ/1000).
- ACK_TIMEOUT_MS, 10, maximum wait for each ACK, in milliseconds.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- req_i  in  1  start a configuration request; sampled only in IDLE.
- data_width_i  in  2  requested data width code (DW_5BIT..DW_8BIT).
- parity_mode_i  in  2  requested parity code (EVEN, ODD, DISABLED1/2).
- stop_bits_i  in  2  requested stop bits code (SB_1BIT, SB_2BIT).
- tx_data_o  out  8  byte to transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts byte.
- rx_data_i  in  8  byte from receiver.
- rx_valid_i  in  1  rx_data_i valid for this cycle (single-cycle strobe).
- busy_o  out  1  request in progress.
- done_o  out  1  one-cycle pulse: configuration accepted.
- fail_o  out  1  one-cycle pulse: request aborted.
- config_o  out  6  committed configuration {stop_bits, parity_mode, data_width}.

Behaviour:
- Reset (rst_n_i low at a clock edge), from any state including mid-request:
  - state IDLE;
  - tx_valid_o=0, tx_data_o=8'h00, busy_o=0, done_o=0, fail_o=0;
  - config_o=6'b00_00_11 (SB_1BIT, EVEN, DW_8BIT);
  - all counters cleared.
- Packet byte format: {4'b0000, code[1:0], id[1:0]}.
  - Packet IDs: DATA_WIDTH_ID=01, PARITY_MODE_ID=10, STOP_BITS_ID=11, END_CONFIGURATION_ID=00.
  - The END packet code is 00.
- TX handshake:
  - A byte transfers on a cycle where tx_valid_o and tx_ready_i are both 1.
  - While tx_valid_o=1 and tx_ready_i=0, tx_data_o is held stable.
  - After a transfer, tx_valid_o drops unless the next byte follows immediately (SYN stream only).
- State machine:
  - IDLE:
    - req_i=1 with stop_bits_i[1]=1 (reserved code): fail_o pulses next cycle, no byte is sent, and the machine stays in IDLE.
    - Otherwise, req_i=1: latch the three codes, set busy_o, go to SEND_SYN. tx_valid_o=1 with SYN_CHAR on the next cycle.
  - SEND_SYN:
    - Present SYN_CHAR continuously; a counter counts transfers.
    - After transfer number SYN_NUMBER, go to SEND_PKT with packet index 0.
  - SEND_PKT:
    - Present the packet for the index: 0=DW, 1=PM, 2=SB, 3=END.
    - On transfer, go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK:
    - The timeout counter increments every cycle.
    - rx_valid_i=1 with rx_data_i==ACK_CHAR:
      - index<3: increment the index and go to SEND_PKT.
      - index==3: commit the latched codes to config_o, pulse done_o, go to IDLE.
    - rx_valid_i=1 with any other byte: fail.
    - Counter reaches ACK_TIMEOUT_MS*COUNT_1MS without a valid ACK: fail.
    - If the timeout expiry and a valid ACK occur in the same cycle, the ACK wins.
- Fail: fail_o pulses for one cycle, busy_o clears, state returns to IDLE, config_o is unchanged.
- busy_o=1 in every state except IDLE. done_o and fail_o are never both 1.
- Ignored inputs:
  - rx_valid_i outside WAIT_ACK, including RX bytes arriving during SYN or packet transmission.
  - req_i while busy.
- Timing:
  - done_o is asserted the cycle after the final ACK strobe; config_o is updated on the same edge.
  - A new req_i is accepted the cycle after done_o or fail_o.
- Timeout counter width: clog2(ACK_TIMEOUT_MS*COUNT_1MS+1) bits; it saturates and never wraps.

Test Plan:
- Nominal request:
  - Stimulus: COUNT_1MS=10; req_i with DW=10, PM=01, SB=01; tx_ready_i always 1; ACK returned 5 cycles after each packet.
  - Required TX sequence: 16,16,16,09,06,07,00.
  - Required response: done_o pulses once; config_o=6'b01_01_10; busy_o low afterwards.
- TX backpressure:
  - Stimulus: tx_ready_i toggled 0/1 every 3 cycles during a nominal request.
  - Required response: tx_data_o stable while stalled; identical byte sequence; done_o pulses.
- Wrong response byte:
  - Stimulus: remote answers 8'h15 (NAK) to the parity packet.
  - Required response: fail_o pulses; no further bytes sent; config_o stays 6'b00_00_11.
- ACK timeout:
  - Stimulus: ACK_TIMEOUT_MS=2, COUNT_1MS=10; no ACK after the DW packet.
  - Required response: fail_o pulses exactly 20 cycles after the DW transfer cycle; config_o unchanged.
- Reserved stop bits and ignored RX:
  - Stimulus: req_i with SB=10.
    - Required response: fail_o next cycle; tx_valid_o never asserted.
  - Stimulus: rx_valid_i with 8'h06 injected during the SYN stream of a nominal request.
    - Required response: the stray byte is ignored; sequence completes normally.
- Reset mid-request:
  - Stimulus: rst_n_i low for 1 cycle while in WAIT_ACK at index 2.
  - Required response: all outputs at reset values next cycle; config_o=6'b00_00_11; a new request afterwards completes.
